// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: phase encoding,
// default phase durations and the BCD conversion used for countdown loads.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GO   = 2'b00,
        PH_STOP = 2'b01,
        PH_WAIT = 2'b10
    } phase_e;

    localparam int DEF_T_STOP  = 45;
    localparam int DEF_T_GO    = 30;
    localparam int DEF_T_WAIT  = 5;
    localparam int DEF_PED_MIN = 5;

    // Valid for 0..99 only; callers pass elaboration-time constants.
    function automatic logic [7:0] to_bcd(input int unsigned v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

endpackage

// File: rtl/traffic_phase_timer_if.sv
// Control and status bundle between the phase timer and its users
// (light state machine, display path, pedestrian button logic).
interface traffic_phase_timer_if;

    logic       hold;
    logic       ped_req;
    logic       timeout45;
    logic       timeout75;
    logic       timeout80;
    logic [1:0] phase;
    logic [3:0] cnt_tens;
    logic [3:0] cnt_ones;
    logic       ped_ack;

    modport master (
        output hold,
        output ped_req,
        input  timeout45,
        input  timeout75,
        input  timeout80,
        input  phase,
        input  cnt_tens,
        input  cnt_ones,
        input  ped_ack
    );

    modport slave (
        input  hold,
        input  ped_req,
        output timeout45,
        output timeout75,
        output timeout80,
        output phase,
        output cnt_tens,
        output cnt_ones,
        output ped_ack
    );

endinterface

// File: rtl/traffic_phase_timer_bcd_down2.sv
// Two-digit BCD down-counter with synchronous load; load wins over dec.
module bcd_down2 #(
    parameter logic [7:0] RST_VAL = 8'h45
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load) begin
            tens_d = load_val[7:4];
            ones_d = load_val[3:0];
        end else if (dec) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            tens_q <= RST_VAL[7:4];
            ones_q <= RST_VAL[3:0];
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer for the two-road light controller: timeout pulses, phase
// mirror, BCD countdown of remaining seconds and pedestrian shortening.
import traffic_pkg::*;

module traffic_phase_timer #(
    parameter int TICKS_PER_SEC = 1,
    parameter int T_STOP        = DEF_T_STOP,
    parameter int T_GO          = DEF_T_GO,
    parameter int T_WAIT        = DEF_T_WAIT,
    parameter int PED_MIN       = DEF_PED_MIN
) (
    input  logic                  clk1,
    input  logic                  rst,
    traffic_phase_timer_if.slave  bus
);

    localparam int TOTAL = T_STOP + T_GO + T_WAIT;
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    localparam logic [6:0] SEC_T45  = 7'(T_STOP - 1);
    localparam logic [6:0] SEC_T75  = 7'(T_STOP + T_GO - 1);
    localparam logic [6:0] SEC_T80  = 7'(TOTAL - 1);
    localparam logic [6:0] SEC_GEND = 7'(T_STOP + T_GO);
    localparam logic [6:0] SEC_PED  = 7'(T_STOP + T_GO - PED_MIN);
    localparam logic [6:0] PED_LIM  = 7'(PED_MIN + 1);

    localparam logic [7:0] BCD_STOP = to_bcd(T_STOP);
    localparam logic [7:0] BCD_GO   = to_bcd(T_GO);
    localparam logic [7:0] BCD_WAIT = to_bcd(T_WAIT);
    localparam logic [7:0] BCD_PED  = to_bcd(PED_MIN);

    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    sec_q, sec_d;
    phase_e        phase_q, phase_d;
    logic          pend_q, pend_d;

    logic       tick;
    logic       t45, t75, t80;
    logic       shorten;
    logic       ack;
    logic [6:0] go_left;
    logic       cnt_load;
    logic       cnt_dec;
    logic [7:0] cnt_val;

    assign tick = (presc_q == PRESC_MAX) && !bus.hold && !rst;

    assign t45 = tick && (sec_q == SEC_T45);
    assign t75 = tick && (sec_q == SEC_T75);
    assign t80 = tick && (sec_q == SEC_T80);

    // Seconds left in GO, only meaningful while phase_q is GO.
    assign go_left = SEC_GEND - sec_q;

    assign shorten = tick && (phase_q == PH_GO) && pend_q
                  && (go_left > PED_LIM);

    assign ack = shorten || (t75 && pend_q);

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        phase_d = phase_q;
        pend_d  = pend_q;

        if (!bus.hold) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (tick) begin
            if (t80) begin
                sec_d = '0;
            end else if (shorten) begin
                sec_d = SEC_PED;
            end else begin
                sec_d = sec_q + 7'd1;
            end

            unique case (1'b1)
                t45:     phase_d = PH_GO;
                t75:     phase_d = PH_WAIT;
                t80:     phase_d = PH_STOP;
                default: phase_d = phase_q;
            endcase
        end

        // A request in the timeout75 cycle is dropped: GO is already ending.
        if (ack) begin
            pend_d = 1'b0;
        end else if (bus.ped_req && (phase_q == PH_GO) && !t75) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sec_q   <= '0;
            phase_q <= PH_STOP;
            pend_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        cnt_val = 8'h00;
        unique case (1'b1)
            t45:     cnt_val = BCD_GO;
            t75:     cnt_val = BCD_WAIT;
            t80:     cnt_val = BCD_STOP;
            shorten: cnt_val = BCD_PED;
            default: cnt_val = 8'h00;
        endcase
    end

    assign cnt_load = t45 || t75 || t80 || shorten;
    assign cnt_dec  = tick && !cnt_load;

    bcd_down2 #(
        .RST_VAL (BCD_STOP)
    ) u_cnt (
        .clk1     (clk1),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tens     (bus.cnt_tens),
        .ones     (bus.cnt_ones)
    );

    assign bus.timeout45 = t45;
    assign bus.timeout75 = t75;
    assign bus.timeout80 = t80;
    assign bus.ped_ack   = ack;
    assign bus.phase     = phase_q;

endmodule
